// File: rtl/lb_pkg.sv
// Shared types and default widths for the line-buffer repeat controller.
package lb_pkg;

  typedef enum logic [1:0] {ST_IDLE, ST_FILL, ST_DRAIN} lb_state_e;

  localparam int LB_ADDR_WIDTH = 6;
  localparam int LB_DATA_WIDTH = 30;

endpackage

// File: rtl/single_port_ram.sv
// Single-port line RAM: synchronous write, combinational read when selected.
module single_port_ram #(
  parameter int ADDR_WIDTH = 6,
  parameter int DATA_WIDTH = 30
) (
  input  logic                  clk,
  input  logic                  cs,
  input  logic                  we,
  input  logic [ADDR_WIDTH-1:0] addr,
  input  logic [DATA_WIDTH-1:0] din,
  output logic [DATA_WIDTH-1:0] dout
);

  logic [DATA_WIDTH-1:0] mem [2**ADDR_WIDTH];

  always_ff @(posedge clk) begin
    if (cs && we) begin
      mem[addr] <= din;
    end
  end

  assign dout = (cs && !we) ? mem[addr] : '0;

endmodule

// File: rtl/line_repeat_ctrl.sv
// Line-buffer controller: fills one line into a single-port RAM, then
// replays it REPEAT times downstream for integer vertical upscaling.
module line_repeat_ctrl
  import lb_pkg::*;
#(
  parameter int ADDR_WIDTH = LB_ADDR_WIDTH,
  parameter int DATA_WIDTH = LB_DATA_WIDTH,
  parameter int LINE_LEN   = 64,
  parameter int REPEAT     = 2
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  i_valid,
  input  logic [DATA_WIDTH-1:0] i_data,
  output logic                  o_ready,
  output logic                  o_valid,
  output logic [DATA_WIDTH-1:0] o_data,
  output logic                  o_last,
  input  logic                  i_ready,
  output logic                  o_ram_cs,
  output logic                  o_ram_we,
  output logic [ADDR_WIDTH-1:0] o_ram_addr,
  output logic [DATA_WIDTH-1:0] o_ram_din,
  input  logic [DATA_WIDTH-1:0] i_ram_dout
);

  localparam int REP_W = $clog2(REPEAT) + 1;
  localparam logic [ADDR_WIDTH-1:0] LAST_ADDR = ADDR_WIDTH'(LINE_LEN - 1);
  localparam logic [REP_W-1:0]      LAST_REP  = REP_W'(REPEAT - 1);

  lb_state_e             state_q, state_d;
  logic [ADDR_WIDTH-1:0] addr_q, addr_d;
  logic [REP_W-1:0]      rep_q, rep_d;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= ST_IDLE;
      addr_q  <= '0;
      rep_q   <= '0;
    end else begin
      state_q <= state_d;
      addr_q  <= addr_d;
      rep_q   <= rep_d;
    end
  end

  always_comb begin
    state_d    = state_q;
    addr_d     = addr_q;
    rep_d      = rep_q;
    o_ready    = 1'b0;
    o_valid    = 1'b0;
    o_data     = '0;
    o_last     = 1'b0;
    o_ram_cs   = 1'b0;
    o_ram_we   = 1'b0;
    o_ram_addr = '0;
    o_ram_din  = '0;

    case (state_q)
      ST_IDLE: begin
        state_d = ST_FILL;
      end

      ST_FILL: begin
        o_ready    = 1'b1;
        o_ram_cs   = i_valid;
        o_ram_we   = i_valid;
        o_ram_addr = addr_q;
        o_ram_din  = i_data;
        if (i_valid) begin
          if (addr_q == LAST_ADDR) begin
            addr_d  = '0;
            rep_d   = '0;
            state_d = ST_DRAIN;
          end else begin
            addr_d = addr_q + ADDR_WIDTH'(1);
          end
        end
      end

      ST_DRAIN: begin
        // Read is combinational, so addr_q holding under backpressure holds o_data too.
        o_ram_cs   = 1'b1;
        o_ram_addr = addr_q;
        o_valid    = 1'b1;
        o_data     = i_ram_dout;
        o_last     = (addr_q == LAST_ADDR);
        if (i_ready) begin
          if (addr_q == LAST_ADDR) begin
            addr_d = '0;
            if (rep_q == LAST_REP) begin
              rep_d   = '0;
              state_d = ST_FILL;
            end else begin
              rep_d = rep_q + REP_W'(1);
            end
          end else begin
            addr_d = addr_q + ADDR_WIDTH'(1);
          end
        end
      end

      default: begin
        state_d = ST_IDLE;
      end
    endcase
  end

endmodule

// File: doc/line_repeat_ctrl.md
# line_repeat_ctrl

Initiator/controller for the line buffer's single-port RAM. It drives the RAM's chip-select, write-enable, address and write-data pins, and consumes the RAM's combinational read data.
- Fill phase: one line of pixels is written from an input stream.
- Drain phase: the stored line is read back REPEAT times on an output stream, giving integer vertical upscaling.
- Placement: between the pixel source and the downstream horizontal scaler.

## Interface
Parameters:
- ADDR_WIDTH, 6: RAM address width.
- DATA_WIDTH, 30: pixel width (RGB 10:10:10).
- LINE_LEN, 64: pixels per line; legal range 1..2**ADDR_WIDTH.
- REPEAT, 2: number of times each line is emitted; REPEAT ≥ 1.

Ports:
- clk  in  1  single clock; all state changes on its rising edge.
- rst_n  in  1  asynchronous, active-low reset.
- i_valid  in  1  input pixel valid.
- i_data  in  DATA_WIDTH  input pixel.
- o_ready  out  1  controller accepts an input pixel this cycle.
- o_valid  out  1  output pixel valid.
- o_data  out  DATA_WIDTH  output pixel.
- o_last  out  1  marks the last pixel of each emitted line.
- i_ready  in  1  downstream accepts an output pixel.
- o_ram_cs  out  1  RAM chip select.
- o_ram_we  out  1  RAM write enable.
- o_ram_addr  out  ADDR_WIDTH  RAM address.
- o_ram_din  out  DATA_WIDTH  RAM write data.
- i_ram_dout  in  DATA_WIDTH  RAM read data. Combinational: valid in the same cycle when cs=1 and we=0.

## Operation
State machine with three states: ST_IDLE, ST_FILL, ST_DRAIN.
- **ST_IDLE**
  - Entered on reset. Moves to ST_FILL unconditionally on the next clock.
  - All outputs are 0.
- **ST_FILL**
  - o_ready=1; o_ram_cs = o_ram_we = i_valid; o_ram_addr = addr; o_ram_din = i_data.
  - On each accepted pixel (i_valid & o_ready), addr increments.
  - When addr == LINE_LEN-1 and a pixel is accepted: addr clears to 0, rep clears to 0, and the state moves to ST_DRAIN.
  - o_valid=0 in this state.
- **ST_DRAIN**
  - o_ready=0; o_ram_cs=1; o_ram_we=0; o_ram_addr = addr.
  - o_valid=1; o_data = i_ram_dout.
  - o_last = (addr == LINE_LEN-1).
  - On each transfer (o_valid & i_ready), addr increments.
  - At addr == LINE_LEN-1 with a transfer, addr clears to 0 and rep increments.
  - If rep == REPEAT-1 at that same transfer: rep clears to 0 and the state moves to ST_FILL.
  - While i_ready=0: addr, rep and o_data hold. RAM contents do not change in drain, so the held data is stable.
- Width rules:
  - addr is ADDR_WIDTH bits wide and never exceeds LINE_LEN-1.
  - rep is $clog2(REPEAT)+1 bits wide and never exceeds REPEAT-1.
  - No arithmetic is performed on pixel data.
- The RAM is never written and read in the same cycle; single-port exclusivity is guaranteed by state.
- While not in ST_FILL, o_ram_din = 0.

## Timing
- Reset values: state=ST_IDLE, addr=0, rep=0.
  - All outputs are 0 while rst_n is low and during the first cycle after release.
  - o_ready rises one clock after reset release.
- Write latency: a pixel accepted on edge N is stored in the RAM at edge N.
- Read latency: zero. o_data follows o_ram_addr combinationally from the RAM.
- Fill→drain: o_valid rises in the cycle after the last fill pixel is accepted.
- Drain→fill: o_ready rises in the cycle after the final o_last transfer.
- Minimum cycles per line group: LINE_LEN·(1+REPEAT), with no bubbles when i_valid and i_ready are held at 1.
- LINE_LEN=1: every pixel is last. Fill lasts 1 cycle, then drain lasts REPEAT cycles with o_last=1 on each.
- REPEAT=1: pass-through with one line of buffering.
- Reset mid-line: state returns to ST_IDLE asynchronously. The partial line is discarded (RAM contents are left stale and are overwritten on the next fill), and no output pixel is emitted until a full new line is filled.
- i_valid during drain is ignored (o_ready=0); the source must hold its data until o_ready is 1.

## Structure
- Shared package lb_pkg:
  - typedef enum logic [1:0] {ST_IDLE, ST_FILL, ST_DRAIN} lb_state_e.
  - Default widths: LB_ADDR_WIDTH=6, LB_DATA_WIDTH=30.
- Single flat module; no sub-module. The RAM is instantiated beside this block by the parent.
- The bench instantiates single_port_ram as the memory model.

## Test plan
All scenarios use LINE_LEN=4, REPEAT=2.
- **Reset:** hold rst_n=0 for 3 cycles, release → o_ready=0 in the first cycle, then 1; o_valid=0; all o_ram_* = 0 until the first i_valid.
- **Nominal:** send pixels 0x11, 0x22, 0x33, 0x44 with i_ready=1 → output 11, 22, 33, 44, 11, 22, 33, 44. o_last is high on both 0x44 beats. RAM writes occur at addr 0..3, and we=0 throughout drain.
- **Backpressure:** drop i_ready for 3 cycles on the second beat → o_data holds 0x22 and o_ram_addr holds 1. The sequence is unchanged, with no duplicated or dropped pixel.
- **Input stall:** gaps in i_valid during fill → no RAM write in gap cycles (cs=0); addresses stay contiguous 0..3.
- **Back-to-back lines:** a second line 0xA0..0xA3 offered during drain → o_ready=0 until the final o_last transfer, rises next cycle, and that line is then emitted twice.
- **Reset mid-drain:** assert rst_n after 5 output beats → outputs are 0 immediately. After release, a fresh 4-pixel line is required before o_valid rises.
